// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the ID-stage interlock controller.
package hazard_pkg;
  localparam int SB_DEPTH = 3;
  localparam int NREG_BITS = 5;
  localparam logic [NREG_BITS-1:0] REG_ZERO = '0;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;
  typedef struct packed {
    logic                 valid;
    logic [NREG_BITS-1:0] dst;
  } sb_entry_t;
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: EX/MEM/WB destination shift register with rs/rt match ports.
module hazard_scoreboard import hazard_pkg::*; #(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  sb_entry_t            ex_i,
  input  logic [NREG_BITS-1:0] rs_i,
  input  logic [NREG_BITS-1:0] rt_i,
  output logic                 rs_hit_o,
  output logic                 rt_hit_o,
  output logic                 empty_o
);
  sb_entry_t sb_q [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= '0;
    end else begin
      sb_q[0] <= ex_i;
      for (int i = 1; i < DEPTH; i++) sb_q[i] <= sb_q[i-1];
    end
  end
  // empty_o looks past the WB entry: it retires on this edge, so the pipe is drained after it
  always_comb begin
    rs_hit_o = 1'b0;
    rt_hit_o = 1'b0;
    empty_o  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rs_hit_o = rs_hit_o | (sb_q[i].valid && sb_q[i].dst == rs_i);
      rt_hit_o = rt_hit_o | (sb_q[i].valid && sb_q[i].dst == rt_i);
      if (i < DEPTH - 1) empty_o = empty_o & !sb_q[i].valid;
    end
  end
endmodule

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: RAW interlock, jump flush, halt drain FSM and perf-counter enable for ID.
module id_hazard_ctrl import hazard_pkg::*; #(
  parameter int SB_DEPTH  = 3,
  parameter int NREG_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [NREG_BITS-1:0] id_rs,
  input  logic [NREG_BITS-1:0] id_rt,
  input  logic                 id_rs_read,
  input  logic                 id_rt_read,
  input  logic                 id_reg_wen,
  input  logic [NREG_BITS-1:0] id_dst,
  input  logic                 id_isJump,
  input  logic                 id_isJR,
  input  logic                 id_halt,
  input  logic                 id_strcnt,
  input  logic                 id_stpcnt,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 bubble_ex,
  output logic                 flush_if,
  output logic                 perf_en,
  output logic                 halted
);
  state_e    state_q, state_d;
  logic      perf_q, perf_d;
  logic      rs_hit, rt_hit, sb_empty, hazard, issue;
  sb_entry_t ex_entry;
  hazard_scoreboard #(.DEPTH(SB_DEPTH)) u_sb (
    .clk(clk), .rst(rst), .ex_i(ex_entry), .rs_i(id_rs), .rt_i(id_rt),
    .rs_hit_o(rs_hit), .rt_hit_o(rt_hit), .empty_o(sb_empty)
  );
  assign hazard = id_valid && state_q == RUN &&
                  ((id_rs_read && id_rs != REG_ZERO && rs_hit) ||
                   (id_rt_read && id_rt != REG_ZERO && rt_hit));
  assign issue = id_valid && !hazard && state_q == RUN;
  // halt and writes to r0 enter the pipe as bubbles
  assign ex_entry = '{valid: issue && id_reg_wen && !id_halt && id_dst != REG_ZERO, dst: id_dst};
  assign perf_en = perf_q;
  assign halted = state_q == HALTED;
  always_comb begin
    state_d   = state_q;
    perf_d    = (issue && id_stpcnt) ? 1'b0 : (issue && id_strcnt) ? 1'b1 : perf_q;
    stall_if  = hazard;
    stall_id  = hazard;
    bubble_ex = hazard;
    flush_if  = issue && (id_isJump || id_isJR);
    case (state_q)
      RUN:     state_d = (issue && id_halt) ? DRAIN : RUN;
      DRAIN: begin
        stall_if  = 1'b1;
        bubble_ex = 1'b1;
        state_d   = sb_empty ? HALTED : DRAIN;
      end
      HALTED:  stall_if = 1'b1;
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      perf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      perf_q  <= perf_d;
    end
  end
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: directed + random stimulus against a cycle-count reference model, queue-based checking.
module tb_id_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic id_valid = 0, id_rs_read = 0, id_rt_read = 0, id_reg_wen = 0;
  logic id_isJump = 0, id_isJR = 0, id_halt = 0, id_strcnt = 0, id_stpcnt = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_dst = 0;
  logic stall_if, stall_id, bubble_ex, flush_if, perf_en, halted;
  always #5 clk = ~clk;
  id_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_read(id_rs_read), .id_rt_read(id_rt_read), .id_reg_wen(id_reg_wen), .id_dst(id_dst),
    .id_isJump(id_isJump), .id_isJR(id_isJR), .id_halt(id_halt), .id_strcnt(id_strcnt),
    .id_stpcnt(id_stpcnt), .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_if(flush_if), .perf_en(perf_en), .halted(halted)
  );
  typedef struct {
    bit v; int rs; int rt; bit rsr; bit rtr; bit wen; int dst;
    bit j; bit jr; bit halt; bit str; bit stp; bit r;
  } stim_t;
  logic [5:0] exp_q[$];
  int tests = 0, fails = 0;
  // Reference model: a register is busy for 3 cycles after its writer issues;
  // halt drains once no writer is still inside the 3-cycle window.
  int cyc, lw[32], last_any, mst;
  bit perf, last_iss;
  task automatic model_reset();
    cyc = 0;
    foreach (lw[i]) lw[i] = -100;
    last_any = -100;
    mst = 0;
    perf = 0;
  endtask
  function automatic stim_t nop();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction
  function automatic stim_t alu(int d, int a, int b);
    stim_t s = nop();
    s.v = 1; s.wen = (d != 0); s.dst = d; s.rs = a; s.rt = b; s.rsr = 1; s.rtr = 1;
    return s;
  endfunction
  task automatic step(input stim_t s, input bit chk = 1);
    bit haz, iss;
    @(posedge clk); #1;
    rst = s.r; id_valid = s.v; id_rs = s.rs[4:0]; id_rt = s.rt[4:0];
    id_rs_read = s.rsr; id_rt_read = s.rtr; id_reg_wen = s.wen; id_dst = s.dst[4:0];
    id_isJump = s.j; id_isJR = s.jr; id_halt = s.halt; id_strcnt = s.str; id_stpcnt = s.stp;
    haz = s.v && mst == 0 && ((s.rsr && s.rs != 0 && cyc - lw[s.rs] <= 3) ||
                              (s.rtr && s.rt != 0 && cyc - lw[s.rt] <= 3));
    iss = s.v && !haz && mst == 0;
    if (chk) exp_q.push_back({haz || mst != 0, haz, haz || mst == 1,
                              iss && (s.j || s.jr), perf, mst == 2});
    last_iss = iss;
    if (s.r) model_reset();
    else begin
      if (iss && s.wen && !s.halt && s.dst != 0) begin lw[s.dst] = cyc; last_any = cyc; end
      if (iss && s.stp) perf = 0; else if (iss && s.str) perf = 1;
      if (mst == 0 && iss && s.halt) mst = 1;
      else if (mst == 1 && cyc >= last_any + 3) mst = 2;
      cyc++;
    end
  endtask
  task automatic issue(input stim_t s);
    for (int k = 0; k < 10; k++) begin
      step(s);
      if (last_iss) break;
    end
  endtask
  initial begin : monitor
    logic [5:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {stall_if, stall_id, bubble_ex, flush_if, perf_en, halted};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL outputs{stall_if,stall_id,bubble_ex,flush_if,perf_en,halted} t=%0t got %b expected %b",
                   $time, a, e);
        end
      end
    end
  end
  initial begin : stimulus
    stim_t s;
    model_reset();
    s = nop(); s.r = 1;
    step(s, 0);
    step(nop());
    issue(alu(3, 1, 2));
    issue(alu(4, 3, 1));
    issue(alu(0, 0, 0));
    issue(alu(6, 0, 0));
    issue(alu(5, 1, 2));
    s = nop(); s.v = 1; s.jr = 1; s.rs = 5; s.rsr = 1;
    issue(s);
    s = nop(); s.v = 1; s.j = 1;
    issue(s);
    repeat (4) step(nop());
    s = nop(); s.v = 1; s.str = 1; s.rs = 6; s.rsr = 1;
    issue(alu(6, 1, 1));
    issue(s);
    for (int k = 0; k < 5; k++) issue(alu(k + 7, 1, 2));
    s = nop(); s.v = 1; s.stp = 1;
    issue(s);
    step(nop());
    s = nop(); s.v = 1; s.str = 1; s.stp = 1;
    issue(s);
    issue(alu(8, 1, 2));
    issue(alu(9, 1, 2));
    s = nop(); s.v = 1; s.halt = 1;
    issue(s);
    repeat (3) step(nop());
    issue(alu(10, 8, 9));
    step(nop());
    s = nop(); s.r = 1;
    step(s);
    step(nop());
    for (int k = 0; k < 3000; k++) begin
      s = nop();
      s.v = $urandom_range(0, 7) != 0;
      s.rs = $urandom_range(0, 5); s.rt = $urandom_range(0, 5);
      s.rsr = $urandom_range(0, 1); s.rtr = $urandom_range(0, 1);
      s.wen = $urandom_range(0, 3) != 0;
      s.dst = $urandom_range(0, 15) == 0 ? 31 : $urandom_range(0, 5);
      s.j = $urandom_range(0, 7) == 0; s.jr = $urandom_range(0, 7) == 0;
      s.halt = $urandom_range(0, 63) == 0;
      s.str = $urandom_range(0, 7) == 0; s.stp = $urandom_range(0, 7) == 0;
      s.r = $urandom_range(0, 79) == 0;
      step(s);
    end
    step(nop());
    repeat (2) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_queue got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
